// File: rtl/gate_sweep_if.sv
// gate_sweep_if: stimulus/result bundle between a sweep checker and its driver.
interface gate_sweep_if #(parameter int ERR_W = 4);
    logic             start;
    logic             gate_out;
    logic             in_a_drv;
    logic             in_b_drv;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic             first_err_valid;
    logic [1:0]       first_err_vec;
    modport master (output start, gate_out, input in_a_drv, in_b_drv, busy, done, pass, err_count, first_err_valid, first_err_vec);
    modport slave  (input start, gate_out, output in_a_drv, in_b_drv, busy, done, pass, err_count, first_err_valid, first_err_vec);
endinterface

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: sweeps a 2-input gate through 00..11 and checks it against a truth table.
module gate_sweep_checker #(
    parameter logic [3:0] TRUTH_TABLE   = 4'b1110,
    parameter int         SETTLE_CYCLES = 2,
    parameter int         REPEAT        = 1,
    parameter int         ERR_W         = 4
) (
    input logic         clk,
    input logic         reset,
    gate_sweep_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES);
    localparam logic [7:0] LAST_SWEEP = 8'(REPEAT - 1);
    state_t           state_q, state_d;
    logic [1:0]       vec_q, vec_d, fvec_q, fvec_d;
    logic [7:0]       settle_q, settle_d, sweep_q, sweep_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             fev_q, fev_d, pass_q, pass_d, mismatch;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            settle_q <= '0;
            sweep_q  <= '0;
            err_q    <= '0;
            fev_q    <= 1'b0;
            fvec_q   <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            sweep_q  <= sweep_d;
            err_q    <= err_d;
            fev_q    <= fev_d;
            fvec_q   <= fvec_d;
            pass_q   <= pass_d;
        end
    end
    assign mismatch = bus.gate_out != TRUTH_TABLE[vec_q];
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        sweep_d  = sweep_q;
        err_d    = err_q;
        fev_d    = fev_q;
        fvec_d   = fvec_q;
        pass_d   = pass_q;
        case (state_q)
            IDLE, DONE: if (bus.start) begin
                state_d  = SETTLE;
                vec_d    = '0;
                settle_d = SETTLE_LD;
                sweep_d  = '0;
                err_d    = '0;
                fev_d    = 1'b0;
                fvec_d   = '0;
                pass_d   = 1'b0;
            end
            SETTLE: begin
                state_d  = settle_q == '0 ? CHECK : SETTLE;
                settle_d = settle_q == '0 ? settle_q : settle_q - 8'd1;
            end
            default: begin
                if (mismatch) begin
                    err_d  = err_q == '1 ? err_q : err_q + ERR_W'(1);
                    fev_d  = 1'b1;
                    fvec_d = fev_q ? fvec_q : vec_q;
                end
                settle_d = SETTLE_LD;
                // pass is judged on the count including this final check
                if (vec_q == 2'b11 && sweep_q == LAST_SWEEP) begin
                    state_d = DONE;
                    pass_d  = err_d == '0;
                end else begin
                    state_d = SETTLE;
                    vec_d   = vec_q + 2'd1;
                    sweep_d = vec_q == 2'b11 ? sweep_q + 8'd1 : sweep_q;
                end
            end
        endcase
    end
    always_comb begin
        bus.in_a_drv        = vec_q[1];
        bus.in_b_drv        = vec_q[0];
        bus.busy            = state_q == SETTLE || state_q == CHECK;
        bus.done            = state_q == DONE;
        bus.pass            = pass_q;
        bus.err_count       = err_q;
        bus.first_err_valid = fev_q;
        bus.first_err_vec   = fvec_q;
    end
endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: randomized sweeps of three checker configurations against a schedule-based model.
module tb_gate_sweep_checker;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    logic       start_r [3];
    logic [1:0] mode_r  [3];
    logic       rnd_r   [3];
    logic [1:0] o_vec   [3];
    logic       o_busy  [3];
    logic       o_done  [3];
    logic       o_pass  [3];
    logic [3:0] o_err   [3];
    logic       o_fev   [3];
    logic [1:0] o_fvec  [3];
    int n_chk = 0;
    int n_pass = 0;
    gate_sweep_if #(.ERR_W(4)) if0 ();
    gate_sweep_if #(.ERR_W(4)) if1 ();
    gate_sweep_if #(.ERR_W(1)) if2 ();
    gate_sweep_checker u0 (.clk(clk), .reset(reset), .bus(if0.slave));
    gate_sweep_checker #(.TRUTH_TABLE(4'b1000)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
    gate_sweep_checker #(.SETTLE_CYCLES(0), .REPEAT(2), .ERR_W(1)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));
    // gate models: 0 = OR, 1 = stuck-at-0, 2 = stuck-at-1, 3 = random bit
    function automatic logic gmod(input logic [1:0] m, input logic a, input logic b, input logic r);
        return m == 2'd0 ? (a | b) : m == 2'd1 ? 1'b0 : m == 2'd2 ? 1'b1 : r;
    endfunction
    assign if0.start = start_r[0];
    assign if1.start = start_r[1];
    assign if2.start = start_r[2];
    assign if0.gate_out = gmod(mode_r[0], if0.in_a_drv, if0.in_b_drv, rnd_r[0]);
    assign if1.gate_out = gmod(mode_r[1], if1.in_a_drv, if1.in_b_drv, rnd_r[1]);
    assign if2.gate_out = gmod(mode_r[2], if2.in_a_drv, if2.in_b_drv, rnd_r[2]);
    assign o_vec[0] = {if0.in_a_drv, if0.in_b_drv};
    assign o_vec[1] = {if1.in_a_drv, if1.in_b_drv};
    assign o_vec[2] = {if2.in_a_drv, if2.in_b_drv};
    assign o_busy[0] = if0.busy;
    assign o_busy[1] = if1.busy;
    assign o_busy[2] = if2.busy;
    assign o_done[0] = if0.done;
    assign o_done[1] = if1.done;
    assign o_done[2] = if2.done;
    assign o_pass[0] = if0.pass;
    assign o_pass[1] = if1.pass;
    assign o_pass[2] = if2.pass;
    assign o_err[0] = if0.err_count;
    assign o_err[1] = if1.err_count;
    assign o_err[2] = 4'(if2.err_count);
    assign o_fev[0] = if0.first_err_valid;
    assign o_fev[1] = if1.first_err_valid;
    assign o_fev[2] = if2.first_err_valid;
    assign o_fvec[0] = if0.first_err_vec;
    assign o_fvec[1] = if1.first_err_vec;
    assign o_fvec[2] = if2.first_err_vec;
    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask
    task automatic check_reset(input int id);
        check("rst_drive", int'(o_vec[id]), 0);
        check("rst_busy", int'(o_busy[id]), 0);
        check("rst_done", int'(o_done[id]), 0);
        check("rst_pass", int'(o_pass[id]), 0);
        check("rst_err", int'(o_err[id]), 0);
        check("rst_fev", int'(o_fev[id]), 0);
        check("rst_fvec", int'(o_fvec[id]), 0);
    endtask
    // Caller is at a negedge. Interval j is the cycle after the j-th edge following the start edge.
    task automatic run(input int id, input int mode, input int s, input int rep, input logic [3:0] tt,
                       input int w, input bit keep, input int mid_j, input int abort_j);
        int n, cnt, fvec, v;
        bit fv;
        logic g;
        n = rep * 4 * (s + 2);
        cnt = 0;
        fvec = 0;
        fv = 1'b0;
        mode_r[id] = 2'(mode);
        start_r[id] = 1'b1;
        @(posedge clk);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            v = (j / (s + 2)) % 4;
            start_r[id] = keep || j == mid_j;
            if (j == abort_j) begin
                reset = 1'b1;
                @(posedge clk);
                @(negedge clk);
                reset = 1'b0;
                start_r[id] = 1'b0;
                check_reset(id);
                return;
            end
            rnd_r[id] = 1'($urandom);
            check("drive", int'(o_vec[id]), v);
            check("busy", int'(o_busy[id]), 1);
            check("early_done", int'(o_done[id]), 0);
            if (j == 0) begin
                check("clr_err", int'(o_err[id]), 0);
                check("clr_fev", int'(o_fev[id]), 0);
                check("clr_pass", int'(o_pass[id]), 0);
            end
            if (j % (s + 2) == s + 1) begin
                g = mode == 0 ? (v != 0) : mode == 1 ? 1'b0 : mode == 2 ? 1'b1 : rnd_r[id];
                if (g != tt[v]) begin
                    cnt++;
                    if (!fv) begin
                        fv = 1'b1;
                        fvec = v;
                    end
                end
            end
        end
        @(negedge clk);
        check("done", int'(o_done[id]), 1);
        check("idle_busy", int'(o_busy[id]), 0);
        check("hold_drive", int'(o_vec[id]), 3);
        check("pass", int'(o_pass[id]), int'(cnt == 0));
        check("err_count", int'(o_err[id]), cnt > (1 << w) - 1 ? (1 << w) - 1 : cnt);
        check("first_valid", int'(o_fev[id]), int'(fv));
        check("first_vec", int'(o_fvec[id]), fvec);
    endtask
    initial begin
        for (int i = 0; i < 3; i++) begin
            start_r[i] = 1'b0;
            mode_r[i] = 2'd0;
            rnd_r[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_reset(i);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) check_reset(i);
        run(0, 0, 2, 1, 4'b1110, 4, 1'b0, -1, -1);
        run(0, 1, 2, 1, 4'b1110, 4, 1'b0, -1, -1);
        run(1, 0, 2, 1, 4'b1000, 4, 1'b0, -1, -1);
        run(1, 0, 2, 1, 4'b1000, 4, 1'b0, -1, -1);
        run(0, 0, 2, 1, 4'b1110, 4, 1'b0, -1, 9);
        run(0, 0, 2, 1, 4'b1110, 4, 1'b0, 5, -1);
        run(2, 2, 0, 2, 4'b1110, 1, 1'b0, -1, -1);
        run(0, 0, 2, 1, 4'b1110, 4, 1'b1, -1, -1);
        run(0, 1, 2, 1, 4'b1110, 4, 1'b0, -1, -1);
        for (int i = 0; i < 24; i++) begin
            case (i % 3)
                0: run(0, 3, 2, 1, 4'b1110, 4, 1'b0, int'($urandom_range(0, 15)), -1);
                1: run(1, 3, 2, 1, 4'b1000, 4, 1'b0, int'($urandom_range(0, 15)), -1);
                default: run(2, 3, 0, 2, 4'b1110, 1, 1'b0, int'($urandom_range(0, 15)), -1);
            endcase
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
